mcm_dsp_stream: RTL and testbench

- Parametrised successor to the single-DSP two-constant multiplier blocks.
- Computes Y_HI = X*C_HI and Y_LO = X*C_LO with one wide multiply. The multiplier is X * (C_HI*2^OFS + C_LO). A borrow correction splits the packed product into the two fields.
- Adds a valid/ready streaming interface, an elastic 2-stage pipeline with full backpressure, and a channel tag that travels with each sample.
- Sits between the sample source and the filter/transform datapath and feeds the adder trees.

---
 rtl/mcm_pkg.sv | 48 ++++
 rtl/mcm_split.sv | 36 +++
 rtl/mcm_dsp_stream.sv | 157 +++++++++++++++
 tb/tb_mcm_dsp_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcm_pkg.sv
// Shared constants and elaboration-time helpers for the multiple-constant
// multiplier family. A single wide multiplier computes X*C_HI and X*C_LO
// together. The two constants are packed into one operand as
// C_HI*2^OFS + C_LO, and the product is later split back into its fields.
//
// Contents:
//   pack_const   - builds the packed multiplier operand
//   signed_width - smallest two's-complement width that holds a constant
//   const_fits   - true if a constant fits its declared signed width and is
//                  not the most-negative code
//   yhi_width /
//   ylo_width    - product field widths
package mcm_pkg;

  // Packed operand: the high constant is shifted up by OFS and the low
  // constant is added. Because the low constant is signed, a negative C_LO
  // borrows from the high field. mcm_split undoes that borrow.
  function automatic longint pack_const(longint c_hi, longint c_lo, int ofs);
    return c_hi * (longint'(1) << ofs) + c_lo;
  endfunction

  // Smallest n such that -2^(n-1) <= c < 2^(n-1).
  function automatic int signed_width(longint c);
    int n;
    n = 63;
    for (int i = 63; i >= 1; i--) begin
      if (c >= -(longint'(1) << (i - 1)) && c < (longint'(1) << (i - 1))) begin
        n = i;
      end
    end
    return n;
  endfunction

  // The most-negative code is excluded. Its magnitude would need one more
  // bit, and that would break the product width bound.
  function automatic bit const_fits(longint c, int w);
    return (signed_width(c) <= w) && (c != -(longint'(1) << (w - 1)));
  endfunction

  function automatic int yhi_width(int w_x, int w_chi);
    return w_x + w_chi - 1;
  endfunction

  function automatic int ylo_width(int w_x, int w_clo);
    return w_x + w_clo - 1;
  endfunction

endpackage

// File: rtl/mcm_split.sv
// Splits a packed product P = X*(C_HI*2^OFS + C_LO) into its two signed fields.
// The logic is purely combinational.
//
// Ports:
//   p_i    - packed product, W_P+1 bits signed. The MSB is a redundant sign
//            copy.
//   y_hi_o - X*C_HI, W_P-OFS bits signed
//   y_lo_o - X*C_LO, OFS bits signed
module mcm_split #(
  parameter int W_P = 31,
  parameter int OFS = 13
) (
  input  logic signed [W_P:0]       p_i,
  output logic signed [W_P-OFS-1:0] y_hi_o,
  output logic signed [OFS-1:0]     y_lo_o
);

  localparam int W_HI = W_P - OFS;

  // The product never needs its top bit because |P| < 2^(W_P-1).
  logic unused_p_msb;
  assign unused_p_msb = p_i[W_P];

  logic [W_HI-1:0] hi_raw;
  logic [W_HI-1:0] borrow;

  always_comb begin
    hi_raw = p_i[W_P-1:OFS];
    // A negative low field took one unit from the high field. Its sign bit is
    // exactly that borrow, so it is added back.
    borrow = {{(W_HI - 1){1'b0}}, p_i[OFS-1]};
    y_hi_o = hi_raw + borrow;
    y_lo_o = p_i[OFS-1:0];
  end

endmodule

// File: rtl/mcm_dsp_stream.sv
// Streaming two-constant multiplier. Each accepted sample X produces
// Y_HI = X*C_HI and Y_LO = X*C_LO using one wide multiply. A channel tag
// travels with every sample. The block is an elastic 2-stage pipeline with
// valid/ready on both sides and full backpressure.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake
//   in_x, in_ch          - signed sample and its channel tag
//   out_valid/out_ready  - output handshake
//   out_ch               - tag of the presented result
//   out_y_hi, out_y_lo   - signed X*C_HI and X*C_LO
//
// Latency is 2 cycles from accept to out_valid, with 1 sample per cycle.
// in_ready depends combinationally on out_ready. No output depends
// combinationally on in_x.
module mcm_dsp_stream
  import mcm_pkg::*;
#(
  parameter int W_X   = 8,
  parameter int C_HI  = 974,
  parameter int W_CHI = 11,
  parameter int C_LO  = 25,
  parameter int W_CLO = 6,
  parameter int W_CH  = 4,
  localparam int W_YHI = yhi_width(W_X, W_CHI),
  localparam int W_YLO = ylo_width(W_X, W_CLO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_X-1:0]   in_x,
  input  logic        [W_CH-1:0]  in_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [W_CH-1:0]  out_ch,
  output logic signed [W_YHI-1:0] out_y_hi,
  output logic signed [W_YLO-1:0] out_y_lo
);

  localparam int OFS = W_YLO;
  localparam int W_P = W_YHI + OFS;
  localparam longint A_PACK = pack_const(C_HI, C_LO, OFS);
  localparam logic signed [W_P:0] A_PACK_V = (W_P + 1)'(A_PACK);

  // Elaboration guards on the constant widths.
  if (!const_fits(C_HI, W_CHI)) begin : gen_chi_bad
    $error("mcm_dsp_stream: C_HI does not fit in W_CHI signed bits");
  end
  if (!const_fits(C_LO, W_CLO)) begin : gen_clo_bad
    $error("mcm_dsp_stream: C_LO does not fit in W_CLO signed bits");
  end

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv;
  logic in_acc;

  always_comb begin
    // S1 moves into S2 when S2 is empty or is being drained this cycle.
    s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_adv;
    in_acc   = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    if (in_acc) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  assign out_valid = s2_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: one wide signed multiply
  // ---------------------------------------------------------------------------
  logic signed [W_P:0] x_ext;
  logic signed [W_P:0] s1_p_q, s1_p_d;
  logic [W_CH-1:0]     s1_ch_q, s1_ch_d;

  always_comb begin
    x_ext   = (W_P + 1)'(in_x);
    s1_p_d  = s1_p_q;
    s1_ch_d = s1_ch_q;
    if (in_acc) begin
      s1_p_d  = x_ext * A_PACK_V;
      s1_ch_d = in_ch;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: field split and output registers
  // ---------------------------------------------------------------------------
  logic signed [W_YHI-1:0] split_hi;
  logic signed [W_YLO-1:0] split_lo;

  mcm_split #(
    .W_P (W_P),
    .OFS (OFS)
  ) u_split (
    .p_i    (s1_p_q),
    .y_hi_o (split_hi),
    .y_lo_o (split_lo)
  );

  logic [W_CH-1:0]         out_ch_q, out_ch_d;
  logic signed [W_YHI-1:0] out_y_hi_q, out_y_hi_d;
  logic signed [W_YLO-1:0] out_y_lo_q, out_y_lo_d;

  always_comb begin
    out_ch_d   = out_ch_q;
    out_y_hi_d = out_y_hi_q;
    out_y_lo_d = out_y_lo_q;
    if (s2_adv) begin
      out_ch_d   = s1_ch_q;
      out_y_hi_d = split_hi;
      out_y_lo_d = split_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_ch_q    <= '0;
      out_ch_q   <= '0;
      out_y_hi_q <= '0;
      out_y_lo_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_p_q     <= s1_p_d;
      s1_ch_q    <= s1_ch_d;
      out_ch_q   <= out_ch_d;
      out_y_hi_q <= out_y_hi_d;
      out_y_lo_q <= out_y_lo_d;
    end
  end

  assign out_ch   = out_ch_q;
  assign out_y_hi = out_y_hi_q;
  assign out_y_lo = out_y_lo_q;

endmodule

// File: tb/tb_mcm_dsp_stream.sv
module tb_mcm_dsp_stream;

  localparam int CHI   = 974;
  localparam int CLO   = 25;
  localparam int NRAND = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_x;
  logic [3:0]        in_ch;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_ch;
  logic signed [17:0] out_y_hi;
  logic signed [12:0] out_y_lo;

  mcm_dsp_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_y_hi  (out_y_hi),
    .out_y_lo  (out_y_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int ch;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  // Inputs change 1 time unit after the edge, and outputs are sampled 4 units
  // later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_ch = '0; out_ready = 1'b0;
    tick; tick;
    #4;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_ch !== 4'd0 || out_y_hi !== 18'sd0 || out_y_lo !== 13'sd0) begin
      bad++; $display("FAIL reset_data: got ch=%0d hi=%0d lo=%0d want 0/0/0",
                      out_ch, out_y_hi, out_y_lo);
    end
    tick;
    rst_n = 1'b1;
    #4;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    tick;
  endtask

  task automatic test_single;
    int xs[4];
    int chs[4];
    xs  = '{1, -1, -128, 127};
    chs = '{3, 5, 9, 15};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_x = 8'(xs[i]); in_ch = 4'(chs[i]);
      #4;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL single_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick;
      in_valid = 1'b0;
      #4;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL single_early[%0d]: out_valid got %b want 0", i, out_valid);
      end
      tick;
      #4;
      total++;
      if (out_valid !== 1'b1 || int'(out_ch) !== chs[i] || int'(out_y_hi) !== xs[i] * CHI ||
          int'(out_y_lo) !== xs[i] * CLO) begin
        bad++;
        $display("FAIL single[%0d] x=%0d: got v=%b ch=%0d hi=%0d lo=%0d want v=1 ch=%0d hi=%0d lo=%0d",
                 i, xs[i], out_valid, out_ch, out_y_hi, out_y_lo, chs[i], xs[i] * CHI,
                 xs[i] * CLO);
      end
      tick;
      #4;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL single_drain[%0d]: out_valid got %b want 0", i, out_valid);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    beat_t b;
    beat_t e;
    bit    exp_v;
    out_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 260; c++) begin
      in_valid = (c < 256);
      b.x = (c < 256) ? ((c < 128) ? c : c - 256) : 0;
      b.ch = c % 16;
      in_x = 8'(b.x); in_ch = 4'(b.ch);
      #4;
      exp_v = (c >= 2) && (c < 258);
      total++;
      if (out_valid !== exp_v || (c < 256 && in_ready !== 1'b1)) begin
        bad++; $display("FAIL b2b_flow c=%0d: got v=%b rdy=%b want v=%b rdy=1",
                        c, out_valid, in_ready, exp_v);
      end
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (int'(out_ch) !== e.ch || int'(out_y_hi) !== e.x * CHI ||
            int'(out_y_lo) !== e.x * CLO) begin
          bad++;
          $display("FAIL b2b_data x=%0d: got ch=%0d hi=%0d lo=%0d want ch=%0d hi=%0d lo=%0d",
                   e.x, out_ch, out_y_hi, out_y_lo, e.ch, e.x * CHI, e.x * CLO);
        end
      end
      if (in_valid && in_ready) sb.push_back(b);
      tick;
    end
    in_valid = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL b2b_left: got %0d pending want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure;
    beat_t bp[4];
    beat_t e;
    int    nacc;
    int    ngot;
    int    idx;
    bit    have_snap;
    logic [3:0]         s_ch;
    logic signed [17:0] s_hi;
    logic signed [12:0] s_lo;
    nacc = 0; ngot = 0; have_snap = 0;
    s_ch = '0; s_hi = '0; s_lo = '0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      bp[i].x  = int'($urandom_range(0, 255)) - 128;
      bp[i].ch = (i + 8) % 16;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idx = (nacc < 4) ? nacc : 3;
      in_valid = (nacc < 4); in_x = 8'(bp[idx].x); in_ch = 4'(bp[idx].ch);
      #4;
      if (out_valid) begin
        if (!have_snap) begin
          have_snap = 1; s_ch = out_ch; s_hi = out_y_hi; s_lo = out_y_lo;
        end else begin
          total++;
          if (out_ch !== s_ch || out_y_hi !== s_hi || out_y_lo !== s_lo) begin
            bad++; $display("FAIL bp_stable c=%0d: got ch=%0d hi=%0d lo=%0d want ch=%0d hi=%0d lo=%0d",
                            c, out_ch, out_y_hi, out_y_lo, s_ch, s_hi, s_lo);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(bp[nacc]);
        nacc++;
      end
      tick;
    end
    #4;
    total++;
    if (nacc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full: got acc=%0d rdy=%b v=%b want acc=2 rdy=0 v=1",
                      nacc, in_ready, out_valid);
    end
    tick;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && ngot < 4; c++) begin
      idx = (nacc < 4) ? nacc : 3;
      in_valid = (nacc < 4); in_x = 8'(bp[idx].x); in_ch = 4'(bp[idx].ch);
      #4;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL bp_extra: got unexpected beat want none");
        end else begin
          e = sb.pop_front();
          total++;
          if (int'(out_ch) !== e.ch || int'(out_y_hi) !== e.x * CHI ||
              int'(out_y_lo) !== e.x * CLO) begin
            bad++;
            $display("FAIL bp_data[%0d]: got ch=%0d hi=%0d lo=%0d want ch=%0d hi=%0d lo=%0d",
                     ngot, out_ch, out_y_hi, out_y_lo, e.ch, e.x * CHI, e.x * CLO);
          end
          ngot++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(bp[nacc]);
        nacc++;
      end
      tick;
    end
    in_valid = 1'b0;
    total++;
    if (ngot != 4 || nacc != 4) begin
      bad++; $display("FAIL bp_count: got out=%0d acc=%0d want 4/4", ngot, nacc);
    end
    tick; tick;
    sb.delete();
  endtask

  task automatic test_random;
    beat_t b;
    beat_t e;
    int    sent;
    int    got;
    int    cyc;
    bit    exp_rdy;
    sent = 0; got = 0; cyc = 0;
    sb.delete();
    b.x  = int'($urandom_range(0, 255)) - 128;
    b.ch = int'($urandom_range(0, 15));
    while ((sent < NRAND || got < NRAND) && cyc < 60000) begin
      in_valid  = (sent < NRAND) && ($urandom_range(0, 1) == 1);
      in_x      = 8'(b.x);
      in_ch     = 4'(b.ch);
      out_ready = ($urandom_range(0, 1) == 1);
      #4;
      // Two beats in flight and a stalled sink is the only case for not ready.
      exp_rdy = !(sb.size() == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rand_extra cyc=%0d: got beat ch=%0d want none", cyc, out_ch);
        end else begin
          e = sb.pop_front();
          if (int'(out_ch) !== e.ch || int'(out_y_hi) !== e.x * CHI ||
              int'(out_y_lo) !== e.x * CLO) begin
            bad++;
            $display("FAIL rand_data[%0d]: got ch=%0d hi=%0d lo=%0d want ch=%0d hi=%0d lo=%0d",
                     got, out_ch, out_y_hi, out_y_lo, e.ch, e.x * CHI, e.x * CLO);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(b);
        sent++;
        b.x  = int'($urandom_range(0, 255)) - 128;
        b.ch = int'($urandom_range(0, 15));
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (sent != NRAND || got != NRAND || sb.size() != 0) begin
      bad++; $display("FAIL rand_count: got sent=%0d recv=%0d pending=%0d want %0d/%0d/0",
                      sent, got, sb.size(), NRAND, NRAND);
    end
    tick; tick;
    sb.delete();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_x = 8'(c + 40); in_ch = 4'(c);
      tick;
    end
    #4;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    tick;
    rst_n = 1'b0; in_valid = 1'b0;
    tick;
    rst_n = 1'b1; out_ready = 1'b1;
    #4;
    total++;
    if (out_valid !== 1'b0 || out_ch !== 4'd0 || out_y_hi !== 18'sd0 || out_y_lo !== 13'sd0) begin
      bad++; $display("FAIL rmid_clear: got v=%b ch=%0d hi=%0d lo=%0d want 0/0/0/0",
                      out_valid, out_ch, out_y_hi, out_y_lo);
    end
    tick;
    #4;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_ghost: got v=%b want 0", out_valid);
    end
    tick;
    in_valid = 1'b1; in_x = 8'sd2; in_ch = 4'd7;
    tick;
    in_valid = 1'b0;
    tick;
    #4;
    total++;
    if (out_valid !== 1'b1 || out_ch !== 4'd7 || int'(out_y_hi) !== 1948 ||
        int'(out_y_lo) !== 50) begin
      bad++; $display("FAIL rmid_after: got v=%b ch=%0d hi=%0d lo=%0d want 1/7/1948/50",
                      out_valid, out_ch, out_y_hi, out_y_lo);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
